rsh_seq: RTL and testbench

Iterative 32-bit right shifter for the micro MIPS datapath, covering SRL/SRA/SRLV/SRAV. It is the right-shift counterpart of the combinational left-shift mux. Instead of a 32-way mux, it applies one log2 stage per cycle (16, 8, 4, 2, 1), which trades latency for area. Operands enter and results leave through valid/ready handshakes, so the ALU issue logic can stall on it like any other multi-cycle unit.

---
 rtl/rsh_pkg.sv | 15 +
 rtl/rsh_stage.sv | 28 ++
 rtl/rsh_seq.sv | 96 +++++++++
 tb/tb_rsh_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsh_pkg.sv
// rsh_pkg: shared types and constants for the iterative right shifter.
// Holds the FSM state encoding and the fixed datapath/stage sizes.
package rsh_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int NUM_STG = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rsh_stage.sv
// rsh_stage: one log2 right-shift stage, shift = 16 >> stg, with fill.
// Ports: val/stg/en/fill in, res out (val passed through when en=0).
module rsh_stage
  import rsh_pkg::*;
(
  input  logic [DATA_W-1:0] val,
  input  logic [2:0]        stg,
  input  logic              en,
  input  logic              fill,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = val;
    unique case (stg)
      3'd0:    shifted = {{16{fill}}, val[31:16]};
      3'd1:    shifted = {{8{fill}},  val[31:8]};
      3'd2:    shifted = {{4{fill}},  val[31:4]};
      3'd3:    shifted = {{2{fill}},  val[31:2]};
      3'd4:    shifted = {fill,       val[31:1]};
      default: shifted = val;
    endcase
    res = en ? shifted : val;
  end

endmodule

// File: rtl/rsh_seq.sv
// rsh_seq: iterative 32-bit right shifter (SRL/SRA), one stage per cycle.
// Ports: clk, rst, in_valid/in_ready/a/shamt/arith, out_valid/out_ready/res.
module rsh_seq
  import rsh_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] shamt,
  input  logic              arith,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res
);

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] amt;
  logic               fill;
  logic [2:0]         stg;

  logic [DATA_W-1:0]  stage_res;
  logic [SHAMT_W-1:0] sel;
  logic               en;
  logic               accept;

  // Only the low shift-amount bits matter.
  logic unused_shamt;
  assign unused_shamt = ^shamt[DATA_W-1:SHAMT_W];

  // Stage stg consumes amt bit (4 - stg): MSB first.
  assign sel = 5'b10000 >> stg;
  assign en  = |(amt & sel);

  assign in_ready = (state == IDLE) ||
                    (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign res      = acc;

  rsh_stage u_stage (
    .val  (acc),
    .stg  (stg),
    .en   (en),
    .fill (fill),
    .res  (stage_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      amt       <= '0;
      fill      <= 1'b0;
      stg       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc   <= a;
            amt   <= shamt[SHAMT_W-1:0];
            fill  <= arith & a[DATA_W-1];
            stg   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= stage_res;
          stg <= stg + 3'd1;
          if (stg == 3'(NUM_STG - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              acc   <= a;
              amt   <= shamt[SHAMT_W-1:0];
              fill  <= arith & a[DATA_W-1];
              stg   <= '0;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsh_seq.sv
// tb_rsh_seq: scoreboard bench for rsh_seq.
// Expected results are queued at issue and popped when the result shows up.
module tb_rsh_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  rsh_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  function automatic logic [31:0] model(input logic [31:0] v,
                                        input logic [31:0] s,
                                        input logic ar);
    logic [31:0] r;
    if (ar) r = $signed(v) >>> s[4:0];
    else    r = v >> s[4:0];
    return r;
  endfunction

  task automatic start_op(input logic [31:0] v,
                          input logic [31:0] s,
                          input logic ar);
    a        = v;
    shamt    = s;
    arith    = ar;
    in_valid = 1'b1;
    q.push_back(model(v, s, ar));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    shamt    = $urandom;
    arith    = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 40);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 32'hDEAD_BEEF;
    shamt     = 32'd4;
    arith     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (res !== 32'h0) begin
      errors++;
      $display("FAIL reset_res got %h want 0", res);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    begin
      int seen = 0;
      repeat (8) begin
        @(posedge clk);
        #1;
        if (out_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL reset_no_capture got %0d valid cycles want 0", seen);
      end
    end
  endtask

  task automatic test_logical;
    int cyc;
    start_op(32'hF000_0001, 32'd4, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL logical_latency got %0d want 5", cyc);
    end
    checks++;
    if (res !== q[0] || res !== 32'h0F00_0000) begin
      errors++;
      $display("FAIL logical_res got %h want %h", res, q[0]);
    end
    void'(q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL logical_consume got %b want 0", out_valid);
    end
  endtask

  task automatic test_arith;
    int cyc;
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      start_op(32'h8000_0000, 32'd31, (i == 0));
      wait_valid(cyc);
      exp = q.pop_front();
      checks++;
      if (res !== exp || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL arith_%0d res %h valid %b want %h", i, res,
                 out_valid, exp);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_zero_shift;
    int cyc;
    logic [31:0] exp;
    start_op(32'h1234_5678, 32'hFFFF_FFE0, 1'b1);
    wait_valid(cyc);
    exp = q.pop_front();
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL zero_latency got %0d want 5", cyc);
    end
    checks++;
    if (res !== exp || exp !== 32'h1234_5678) begin
      errors++;
      $display("FAIL zero_res got %h want %h", res, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad;
    logic [31:0] exp;
    start_op(32'h8765_4321, 32'd7, 1'b1);
    wait_valid(cyc);
    exp = q[0];
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (res !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles res %h want %h", bad,
               res, exp);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL bp_first_res got %h want %h", res, exp);
    end
    void'(q.pop_front());
    out_ready = 1'b1;
    a         = 32'hFFFF_0000;
    shamt     = 32'd16;
    arith     = 1'b1;
    in_valid  = 1'b1;
    q.push_back(model(a, shamt, arith));
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_in_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consumed got %b want 0", out_valid);
    end
    wait_valid(cyc);
    exp = q.pop_front();
    checks++;
    if (cyc != 5 || res !== exp || exp !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL bp_second cyc %0d res %h want 5 %h", cyc, res, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    logic [31:0] exp;
    start_op(32'hA5A5_A5A5, 32'd13, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(q.pop_back());
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_no_valid got %0d valid cycles want 0", seen);
    end
    start_op(32'h7FFF_FFFF, 32'd3, 1'b0);
    wait_valid(cyc);
    exp = q.pop_front();
    checks++;
    if (cyc != 5 || res !== exp) begin
      errors++;
      $display("FAIL rstmid_next cyc %0d res %h want 5 %h", cyc, res, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    int cyc;
    int bad;
    logic [31:0] exp;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start_op($urandom, $urandom, 1'($urandom));
      wait_valid(cyc);
      exp = q.pop_front();
      if (cyc != 5 || res !== exp) begin
        bad++;
        $display("FAIL random_%0d res %h want %h cyc %0d", i, res, exp, cyc);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
  endtask

  initial begin
    test_reset;
    test_logical;
    test_arith;
    test_zero_shift;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
